// File: rtl/time_source_sel_if.sv
// Source-selection bus: N time words with PM flags in, selected word plus status out.
// master drives the sources and requests; slave is the selector.
interface time_source_sel_if #(
  parameter int NUM_SRC = 3,
  parameter int W       = 13
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC*W-1:0] src_data;
  logic [NUM_SRC-1:0]   src_pm;
  logic                 sel_valid;
  logic [SW-1:0]        sel_idx;
  logic                 act;
  logic [W-1:0]         disp_data;
  logic                 disp_pm;
  logic                 disp_blank;
  logic [SW-1:0]        cur_src;
  logic                 sel_err;

  modport master (
    output src_data, src_pm, sel_valid, sel_idx, act,
    input  disp_data, disp_pm, disp_blank, cur_src, sel_err
  );

  modport slave (
    input  src_data, src_pm, sel_valid, sel_idx, act,
    output disp_data, disp_pm, disp_blank, cur_src, sel_err
  );
endinterface

// File: rtl/time_source_sel.sv
// Registered N-way time source selector with idle revert to the live clock and edit blink.
// One-cycle latency from select/source to display; no backpressure, requests are never stalled.
module time_source_sel #(
  parameter int                 NUM_SRC    = 3,
  parameter int                 W          = 13,
  parameter int                 TIMEOUT    = 50_000_000,
  parameter int                 BLINK_HALF = 12_500_000,
  parameter logic [NUM_SRC-1:0] EDIT_MASK  = 3'b010
) (
  input logic              clk,
  input logic              reset,
  time_source_sel_if.slave bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [SW:0]   SRC_LIM    = (SW + 1)'(NUM_SRC);

  typedef enum logic [1:0] {LIVE, HOLD, EDIT} state_t;

  state_t        state;
  logic [SW-1:0] cur_src;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic [W-1:0]  disp_data;
  logic          disp_pm;
  logic          disp_blank;
  logic          sel_err;

  logic          accept;
  logic          reject;
  logic          expire;
  logic [SW-1:0] nxt_src;
  logic          nxt_edit;

  always_comb begin
    accept   = bus.sel_valid && ({1'b0, bus.sel_idx} < SRC_LIM);
    reject   = bus.sel_valid && !accept;
    // A select or activity in the expiry cycle keeps the current view.
    expire   = (state != LIVE) && (TIMEOUT != 0) && (idle_cnt == IDLE_LAST)
               && !accept && !bus.act;
    nxt_src  = cur_src;
    if (accept) begin
      nxt_src = bus.sel_idx;
    end else if (expire) begin
      nxt_src = '0;
    end
    nxt_edit = (nxt_src != '0) && EDIT_MASK[nxt_src];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LIVE;
      cur_src    <= '0;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      disp_data  <= '0;
      disp_pm    <= 1'b0;
      disp_blank <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err   <= reject;
      cur_src   <= nxt_src;
      disp_data <= bus.src_data[int'(nxt_src)*W +: W];
      disp_pm   <= bus.src_pm[nxt_src];

      if (nxt_src == '0) begin
        state <= LIVE;
      end else if (nxt_edit) begin
        state <= EDIT;
      end else begin
        state <= HOLD;
      end

      if ((nxt_src == '0) || accept || bus.act) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      // Any interaction shows the digits at once and restarts the blink phase.
      if (!nxt_edit || accept || bus.act) begin
        blink_cnt  <= '0;
        disp_blank <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt  <= '0;
        disp_blank <= !disp_blank;
      end else begin
        blink_cnt  <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.cur_src    = cur_src;
  assign bus.disp_data  = disp_data;
  assign bus.disp_pm    = disp_pm;
  assign bus.disp_blank = disp_blank;
  assign bus.sel_err    = sel_err;
endmodule

// File: tb/tb_time_source_sel.sv
// Directed bench for time_source_sel: vector table plus timeout, collision, error and reset sequences.
module tb_time_source_sel;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  time_source_sel_if #(.NUM_SRC(3), .W(8)) bus ();

  time_source_sel #(
    .NUM_SRC(3), .W(8), .TIMEOUT(10), .BLINK_HALF(4), .EDIT_MASK(3'b010)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [1:0]  idx;
    logic        act;
    logic [23:0] d;
    logic [2:0]  pm;
    logic [1:0]  ecur;
    logic [7:0]  edata;
    logic        epm;
    logic        eblank;
    logic        eerr;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [1:0] idx, input logic a);
    bus.sel_valid = sv;
    bus.sel_idx   = idx;
    bus.act       = a;
  endtask

  localparam logic [23:0] D1 = 24'h332211;
  localparam logic [23:0] D2 = 24'h442211;
  localparam logic [23:0] D3 = 24'h442255;

  initial begin
    // sv idx act data pm | cur data pm blank err
    tbl[0]  = '{1'b0, 2'd0, 1'b0, D1, 3'b100, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, D1, 3'b100, 2'd2, 8'h33, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, D2, 3'b100, 2'd2, 8'h44, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, D2, 3'b100, 2'd2, 8'h44, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, D2, 3'b100, 2'd2, 8'h44, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, D2, 3'b100, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, D3, 3'b001, 2'd0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, D3, 3'b001, 2'd1, 8'h22, 1'b0, 1'b0, 1'b0};
    for (int i = 8; i <= 24; i++) begin
      tbl[i] = '{1'b0, 2'd0, 1'b0, D3, 3'b001, 2'd1, 8'h22, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 11; i <= 14; i++) tbl[i].eblank = 1'b1;
    tbl[17].act = 1'b1;
    tbl[21].eblank = 1'b1;
    tbl[22].act = 1'b1;
    tbl[24].sv = 1'b1;
    tbl[24].idx = 2'd1;
    tbl[25] = '{1'b1, 2'd2, 1'b0, D3, 3'b001, 2'd2, 8'h44, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 2'd0, 1'b0, D3, 3'b001, 2'd0, 8'h55, 1'b1, 1'b0, 1'b0};

    reset        = 1'b1;
    bus.src_data = D1;
    bus.src_pm   = 3'b100;
    drive(1'b0, 2'd0, 1'b0);
    step();
    step();
    chk("rst_cur", int'(bus.cur_src), 0);
    chk("rst_data", int'(bus.disp_data), 0);
    chk("rst_pm", int'(bus.disp_pm), 0);
    chk("rst_blank", int'(bus.disp_blank), 0);
    chk("rst_err", int'(bus.sel_err), 0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].sv, tbl[i].idx, tbl[i].act);
      bus.src_data = tbl[i].d;
      bus.src_pm   = tbl[i].pm;
      step();
      chk($sformatf("v%0d_cur", i), int'(bus.cur_src), int'(tbl[i].ecur));
      chk($sformatf("v%0d_data", i), int'(bus.disp_data), int'(tbl[i].edata));
      chk($sformatf("v%0d_pm", i), int'(bus.disp_pm), int'(tbl[i].epm));
      chk($sformatf("v%0d_blank", i), int'(bus.disp_blank), int'(tbl[i].eblank));
      chk($sformatf("v%0d_err", i), int'(bus.sel_err), int'(tbl[i].eerr));
    end

    // Plain timeout: select edge plus ten idle edges returns to live.
    for (int k = 0; k < 12; k++) begin
      drive(k == 0, 2'd2, 1'b0);
      step();
      chk($sformatf("to_cur_k%0d", k), int'(bus.cur_src), (k < 10) ? 2 : 0);
      if (k == 10) chk("to_live_data", int'(bus.disp_data), 8'h55);
    end

    // Activity at cycle 9 restarts the idle window.
    for (int k = 0; k < 21; k++) begin
      drive(k == 0, 2'd2, k == 9);
      step();
      chk($sformatf("toact_cur_k%0d", k), int'(bus.cur_src), (k < 19) ? 2 : 0);
    end

    // Select landing on the expiry cycle wins over the revert.
    for (int k = 0; k < 12; k++) begin
      drive((k == 0) || (k == 10), (k == 0) ? 2'd2 : 2'd1, 1'b0);
      step();
      chk($sformatf("coll_cur_k%0d", k), int'(bus.cur_src), (k < 10) ? 2 : 1);
    end

    drive(1'b1, 2'd3, 1'b0);
    step();
    chk("err_pulse", int'(bus.sel_err), 1);
    chk("err_cur", int'(bus.cur_src), 1);
    drive(1'b0, 2'd0, 1'b0);
    step();
    chk("err_clear", int'(bus.sel_err), 0);
    chk("err_cur_hold", int'(bus.cur_src), 1);

    // Reset in the middle of an EDIT blank phase.
    drive(1'b1, 2'd1, 1'b0);
    step();
    drive(1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_blank", int'(bus.disp_blank), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_cur", int'(bus.cur_src), 0);
    chk("mid_rst_blank", int'(bus.disp_blank), 0);
    chk("mid_rst_data", int'(bus.disp_data), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("post_rst_cur_k%0d", k), int'(bus.cur_src), 0);
      chk($sformatf("post_rst_blank_k%0d", k), int'(bus.disp_blank), 0);
      chk($sformatf("post_rst_data_k%0d", k), int'(bus.disp_data), 8'h55);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
